cpu_control: RTL and testbench

CPU_CONTROL -- requirements
Module: cpu_control

---
 rtl/cpu_control.sv | 172 +++++++++++++++++
 tb/tb_cpu_control.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control.sv
// Multi-cycle control unit for a small 4-register accumulator-style CPU.
// Drives an external combinational ALU and fetches 12-bit instructions one at a time.
module cpu_control #(
    parameter int PC_W   = 8,
    parameter int DATA_W = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_valid,
    input  logic [11:0]       imem_data,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic [PC_W-1:0]   pc,
    output logic              retire,
    output logic              illegal,
    output logic              halted,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALTED    = 3'd4
    } state_t;

    localparam logic [3:0]        OP_NOP  = 4'b1011;
    localparam logic [3:0]        OP_HALT = 4'b1111;
    localparam logic [PC_W-1:0]   PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] D_ZERO  = {DATA_W{1'b0}};

    state_t            state_q;
    logic [PC_W-1:0]   pc_q;
    logic [11:0]       instr_q;
    logic [DATA_W-1:0] regs_q [4];
    logic [3:0]        alu_op_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [DATA_W-1:0] result_q;
    logic              wr_q;
    logic              imem_req_q;
    logic              retire_q;
    logic              illegal_q;
    logic              halted_q;

    logic [3:0]        op_d;
    logic [DATA_W-1:0] alu_a_d;
    logic [DATA_W-1:0] alu_b_d;
    logic              wr_d;

    // Operand selection for the latched instruction; anything not a real ALU op becomes a NOP.
    always_comb begin
        op_d    = OP_NOP;
        alu_a_d = D_ZERO;
        alu_b_d = D_ZERO;
        wr_d    = 1'b0;
        case (instr_q[11:8])
            4'b0000, 4'b0001, 4'b0011, 4'b0111: begin
                op_d    = instr_q[11:8];
                alu_a_d = regs_q[instr_q[7:6]];
                alu_b_d = regs_q[instr_q[5:4]];
                wr_d    = 1'b1;
            end
            4'b0010, 4'b0100, 4'b0101, 4'b0110: begin
                op_d    = instr_q[11:8];
                alu_a_d = regs_q[instr_q[5:4]];
                wr_d    = 1'b1;
            end
            4'b1000, 4'b1001, 4'b1010: begin
                op_d    = instr_q[11:8];
                alu_a_d = regs_q[instr_q[7:6]];
                alu_b_d = {{(DATA_W-6){1'b0}}, instr_q[5:0]};
                wr_d    = 1'b1;
            end
            default: begin
                op_d    = OP_NOP;
                alu_a_d = D_ZERO;
                alu_b_d = D_ZERO;
                wr_d    = 1'b0;
            end
        endcase
    end

    // Instruction sequencer, register file and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_FETCH;
            pc_q       <= {PC_W{1'b0}};
            instr_q    <= 12'h000;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= D_ZERO;
            end
            alu_op_q   <= OP_NOP;
            alu_a_q    <= D_ZERO;
            alu_b_q    <= D_ZERO;
            result_q   <= D_ZERO;
            wr_q       <= 1'b0;
            imem_req_q <= 1'b0;
            retire_q   <= 1'b0;
            illegal_q  <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    // The first cycle out of reset only raises the request.
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                    end else if (imem_valid) begin
                        instr_q    <= imem_data;
                        pc_q       <= pc_q + PC_ONE;
                        imem_req_q <= 1'b0;
                        illegal_q  <= (imem_data[11:10] == 2'b11) && (imem_data[9:8] != 2'b11);
                        state_q    <= S_DECODE;
                    end else begin
                        imem_req_q <= 1'b1;
                    end
                end
                S_DECODE: begin
                    alu_op_q <= op_d;
                    alu_a_q  <= alu_a_d;
                    alu_b_q  <= alu_b_d;
                    wr_q     <= wr_d;
                    if (instr_q[11:8] == OP_HALT) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALTED;
                    end else begin
                        state_q  <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    result_q <= alu_result;
                    retire_q <= 1'b1;
                    state_q  <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    if (wr_q) begin
                        regs_q[instr_q[7:6]] <= result_q;
                    end
                    imem_req_q <= 1'b1;
                    state_q    <= S_FETCH;
                end
                S_HALTED: begin
                    state_q <= S_HALTED;
                end
                default: begin
                    imem_req_q <= 1'b0;
                    state_q    <= S_FETCH;
                end
            endcase
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign retire    = retire_q;
    assign illegal   = illegal_q;
    assign halted    = halted_q;
    assign dbg_data  = regs_q[dbg_sel];

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: a reference ALU, a table of instructions with
// hand-computed results, and hand-written reset/halt/wrap sequences.
module tb_cpu_control;

    localparam int PC_W   = 8;
    localparam int DATA_W = 9;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_valid = 1'b0;
    logic [11:0]       imem_data = 12'h000;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic [PC_W-1:0]   pc;
    logic              retire;
    logic              illegal;
    logic              halted;
    logic [1:0]        dbg_sel = 2'd0;
    logic [DATA_W-1:0] dbg_data;

    int tests  = 0;
    int failed = 0;
    int exp_pc = 0;

    typedef struct {
        logic [11:0]       instr;
        int                delay;
        logic [3:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [1:0]        sel;
        logic [DATA_W-1:0] val;
        logic              ill;
    } vec_t;

    vec_t vecs[17];
    vec_t sb[$];
    vec_t nop_v;

    cpu_control #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .pc         (pc),
        .retire     (retire),
        .illegal    (illegal),
        .halted     (halted),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    // Reference ALU for the opcode set.
    always_comb begin
        case (alu_op)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = ~alu_a;
            4'b0011: alu_result = alu_a + alu_b;
            4'b0100: alu_result = alu_a;
            4'b0101: alu_result = alu_a << 1;
            4'b0110: alu_result = alu_a >> 1;
            4'b0111: alu_result = alu_a - alu_b;
            4'b1000: alu_result = alu_a + alu_b;
            4'b1001: alu_result = alu_a - alu_b;
            4'b1010: alu_result = alu_b;
            default: alu_result = {DATA_W{1'b0}};
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", int'(imem_req), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        imem_valid = 1'b0;
        reset_n    = 1'b0;
        #1;
        chk("rst_pc", int'(pc), 0);
        chk("rst_req", int'(imem_req), 0);
        chk("rst_alu_op", int'(alu_op), 11);
        chk("rst_alu_a", int'(alu_a), 0);
        chk("rst_alu_b", int'(alu_b), 0);
        chk("rst_pulses", int'({retire, illegal, halted}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_pc  = 0;
        sb.delete();
    endtask

    // One full instruction: fetch with optional wait, then check each stage.
    task automatic do_instr(input vec_t v);
        vec_t e;
        wait_req();
        chk("fetch_addr", int'(imem_addr), exp_pc);
        dbg_sel = v.sel;
        for (int k = 0; k < v.delay; k++) begin
            @(negedge clk);
            chk("req_hold", int'(imem_req), 1);
            chk("addr_hold", int'(imem_addr), exp_pc);
        end
        imem_valid = 1'b1;
        imem_data  = v.instr;
        sb.push_back(v);
        exp_pc = (exp_pc + 1) % 256;
        @(negedge clk);
        // Keep a valid strobe with junk data alive outside FETCH; it must be ignored.
        imem_data = 12'hFFF;
        chk("illegal_dec", int'(illegal), int'(sb[0].ill));
        chk("retire_dec", int'(retire), 0);
        chk("pc_dec", int'(pc), exp_pc);
        @(negedge clk);
        chk("alu_op", int'(alu_op), int'(sb[0].op));
        chk("alu_a", int'(alu_a), int'(sb[0].a));
        chk("alu_b", int'(alu_b), int'(sb[0].b));
        chk("illegal_exe", int'(illegal), 0);
        @(negedge clk);
        imem_valid = 1'b0;
        chk("retire_wb", int'(retire), 1);
        chk("alu_op_wb", int'(alu_op), int'(sb[0].op));
        e = sb.pop_front();
        @(negedge clk);
        chk("reg_value", int'(dbg_data), int'(e.val));
        chk("retire_off", int'(retire), 0);
        chk("req_next", int'(imem_req), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           instr     dly op     a        b       sel   val      ill
        vecs[0]  = '{12'hA45, 0, 4'hA, 9'd0,   9'd5,  2'd1, 9'd5,   1'b0}; // MOVI R1,5
        vecs[1]  = '{12'h843, 0, 4'h8, 9'd5,   9'd3,  2'd1, 9'd8,   1'b0}; // ADDI R1,3
        vecs[2]  = '{12'hA83, 3, 4'hA, 9'd0,   9'd3,  2'd2, 9'd3,   1'b0}; // MOVI R2,3
        vecs[3]  = '{12'h760, 0, 4'h7, 9'd8,   9'd3,  2'd1, 9'd5,   1'b0}; // SUB R1,R2
        vecs[4]  = '{12'h4D0, 0, 4'h4, 9'd5,   9'd0,  2'd3, 9'd5,   1'b0}; // MOV R3,R1
        vecs[5]  = '{12'h5F0, 0, 4'h5, 9'd5,   9'd0,  2'd3, 9'd10,  1'b0}; // SLL R3,R3
        vecs[6]  = '{12'h0D0, 0, 4'h0, 9'd10,  9'd5,  2'd3, 9'd0,   1'b0}; // AND R3,R1
        vecs[7]  = '{12'h1E0, 0, 4'h1, 9'd0,   9'd3,  2'd3, 9'd3,   1'b0}; // OR R3,R2
        vecs[8]  = '{12'h220, 0, 4'h2, 9'd3,   9'd0,  2'd0, 9'd508, 1'b0}; // NOT R0,R2
        vecs[9]  = '{12'h600, 0, 4'h6, 9'd508, 9'd0,  2'd0, 9'd254, 1'b0}; // SRL R0,R0
        vecs[10] = '{12'h310, 1, 4'h3, 9'd254, 9'd5,  2'd0, 9'd259, 1'b0}; // ADD R0,R1
        vecs[11] = '{12'h984, 0, 4'h9, 9'd3,   9'd4,  2'd2, 9'd511, 1'b0}; // SUBI R2,4
        vecs[12] = '{12'h881, 0, 4'h8, 9'd511, 9'd1,  2'd2, 9'd0,   1'b0}; // ADDI R2,1
        vecs[13] = '{12'hD50, 0, 4'hB, 9'd0,   9'd0,  2'd1, 9'd5,   1'b1}; // undefined 1101
        vecs[14] = '{12'hB00, 0, 4'hB, 9'd0,   9'd0,  2'd1, 9'd5,   1'b0}; // NOP
        vecs[15] = '{12'hA3F, 0, 4'hA, 9'd259, 9'd63, 2'd0, 9'd63,  1'b0}; // MOVI R0,63
        vecs[16] = '{12'hE00, 2, 4'hB, 9'd0,   9'd0,  2'd0, 9'd63,  1'b1}; // undefined 1110
        nop_v    = '{12'hB00, 0, 4'hB, 9'd0,   9'd0,  2'd0, 9'd0,   1'b0};

        do_reset();
        foreach (vecs[i]) do_instr(vecs[i]);
        chk("pc_after_table", int'(pc), 17);

        // Reset asserted during EXECUTE of ADDI R0,7.
        do_reset();
        dbg_sel = 2'd0;
        wait_req();
        imem_valid = 1'b1;
        imem_data  = 12'h807;
        @(negedge clk);
        imem_valid = 1'b0;
        @(negedge clk);
        chk("mid_alu_op", int'(alu_op), 8);
        chk("mid_alu_b", int'(alu_b), 7);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_alu_op", int'(alu_op), 11);
        chk("mid_rst_alu_b", int'(alu_b), 0);
        chk("mid_rst_pc", int'(pc), 0);
        chk("mid_rst_req", int'(imem_req), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_req", int'(imem_req), 1);
        chk("restart_addr", int'(imem_addr), 0);
        repeat (4) @(negedge clk);
        chk("r0_unwritten", int'(dbg_data), 0);
        chk("retire_none", int'(retire), 0);

        // HALT fetched at pc=4.
        do_reset();
        for (int i = 0; i < 4; i++) do_instr(nop_v);
        wait_req();
        chk("halt_addr", int'(imem_addr), 4);
        imem_valid = 1'b1;
        imem_data  = 12'hF00;
        @(negedge clk);
        chk("halt_dec_halted", int'(halted), 0);
        @(negedge clk);
        chk("halted", int'(halted), 1);
        chk("halt_req", int'(imem_req), 0);
        chk("halt_pc", int'(pc), 5);
        chk("halt_alu_op", int'(alu_op), 11);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("halt_hold_req", int'(imem_req), 0);
            chk("halt_hold_pc", int'(pc), 5);
            chk("halt_hold_retire", int'(retire), 0);
        end
        imem_valid = 1'b0;

        // Program counter wrap from 255 to 0.
        do_reset();
        for (int i = 0; i < 255; i++) do_instr(nop_v);
        chk("pre_wrap_addr", int'(imem_addr), 255);
        do_instr(nop_v);
        chk("wrapped_pc", int'(pc), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
